sparse_mem_responder: RTL

SPARSE_MEM_RESPONDER -- requirements
Module: sparse_mem_responder

---
 rtl/sparse_mem_responder.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/sparse_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : sparse_mem_responder (+ sparse_mem_responder_fifo)
// Brief    : Word-addressed 64-bit memory serving tagged in-order loads through
//            request/response FIFOs, with a preload write port.
// Revision : 1.0
// ============================================================================

module sparse_mem_responder_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !push_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Storage needs no reset; a push into a full FIFO alongside a pop reuses the
  // head slot, whose old contents are read out combinationally before the edge.
  always_ff @(posedge clk) begin
    if (push_i) begin
      store_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = store_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module sparse_mem_responder #(
  parameter int MEM_DEPTH  = 1048576,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_mem_ld,
  input  logic [47:0] req_mem_addr,
  input  logic [1:0]  req_mem_tag,
  output logic        req_mem_stall,
  output logic        rsp_mem_push,
  output logic [1:0]  rsp_mem_tag,
  output logic [63:0] rsp_mem_q,
  input  logic        rsp_mem_stall,
  input  logic        wr_en,
  input  logic [47:0] wr_addr,
  input  logic [63:0] wr_data,
  output logic        addr_err
);
  localparam int              c_AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int              c_CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [44:0]     c_MEM_WORDS = 45'(MEM_DEPTH);
  localparam logic [c_CW-1:0] c_FULL      = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_STALL_AT  = c_CW'(FIFO_DEPTH - 2);

  logic [46:0]     w_req_rdata;
  logic [c_CW-1:0] w_req_cnt;
  logic [c_CW-1:0] w_req_cnt_nxt;
  logic            w_req_full;
  logic            w_req_push;
  logic            w_req_pop;
  logic            w_req_drop;
  logic            w_credit_ok;
  logic [44:0]     w_rd_idx;
  logic            w_rd_oor;
  logic [44:0]     w_wr_idx;
  logic            w_wr_ok;
  logic            w_wr_bad;
  logic [65:0]     w_rsp_wdata;
  logic [65:0]     w_rsp_rdata;
  logic [c_CW-1:0] w_rsp_cnt;
  logic            w_rsp_push;
  logic            w_rsp_pop;
  logic            unused_addr_lsbs;

  logic            rd_vld_q;
  logic [1:0]      rd_tag_q;
  logic            rd_oor_q;
  logic [63:0]     rd_data_q;
  logic            stall_q;
  logic            push_q;
  logic [1:0]      tag_q;
  logic [63:0]     data_q;
  logic            err_q;
  logic [63:0]     mem [MEM_DEPTH];

  assign unused_addr_lsbs = ^{req_mem_addr[2:0], wr_addr[2:0]};

  // Response-side credit counts the read in flight so the response FIFO can
  // never overflow when the array result lands.
  assign w_credit_ok = (w_rsp_cnt + c_CW'(rd_vld_q)) < c_FULL;
  assign w_req_full  = (w_req_cnt == c_FULL);
  assign w_req_pop   = !rst && (w_req_cnt != '0) && w_credit_ok;
  assign w_req_push  = !rst && req_mem_ld && (!w_req_full || w_req_pop);
  assign w_req_drop  = !rst && req_mem_ld && w_req_full && !w_req_pop;
  assign w_req_cnt_nxt = w_req_cnt + c_CW'(w_req_push) - c_CW'(w_req_pop);

  sparse_mem_responder_fifo #(
    .WIDTH (47),
    .DEPTH (FIFO_DEPTH),
    .CW    (c_CW)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_req_push),
    .pop_i   (w_req_pop),
    .data_i  ({req_mem_addr[47:3], req_mem_tag}),
    .data_o  (w_req_rdata),
    .count_o (w_req_cnt)
  );

  assign w_rd_idx = w_req_rdata[46:2];
  assign w_rd_oor = (w_rd_idx >= c_MEM_WORDS);
  assign w_wr_idx = wr_addr[47:3];
  assign w_wr_ok  = !rst && wr_en && (w_wr_idx < c_MEM_WORDS);
  assign w_wr_bad = !rst && wr_en && (w_wr_idx >= c_MEM_WORDS);

  // Read and write share one process so a same-word collision yields old data.
  always_ff @(posedge clk) begin
    if (w_req_pop && !w_rd_oor) begin
      rd_data_q <= mem[w_rd_idx[c_AW-1:0]];
    end
    if (w_wr_ok) begin
      mem[w_wr_idx[c_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_tag_q <= '0;
      rd_oor_q <= 1'b0;
    end else begin
      rd_vld_q <= w_req_pop;
      rd_tag_q <= w_req_rdata[1:0];
      rd_oor_q <= w_rd_oor;
    end
  end

  assign w_rsp_push  = !rst && rd_vld_q;
  assign w_rsp_wdata = {rd_tag_q, rd_oor_q ? 64'h0 : rd_data_q};
  assign w_rsp_pop   = !rst && (w_rsp_cnt != '0) && !rsp_mem_stall;

  sparse_mem_responder_fifo #(
    .WIDTH (66),
    .DEPTH (FIFO_DEPTH),
    .CW    (c_CW)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_rsp_push),
    .pop_i   (w_rsp_pop),
    .data_i  (w_rsp_wdata),
    .data_o  (w_rsp_rdata),
    .count_o (w_rsp_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= 1'b0;
      push_q  <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= (w_req_cnt_nxt >= c_STALL_AT);
      push_q  <= w_rsp_pop;
      tag_q   <= w_rsp_pop ? w_rsp_rdata[65:64] : 2'b00;
      data_q  <= w_rsp_pop ? w_rsp_rdata[63:0] : 64'h0;
      if (w_req_drop || (w_req_pop && w_rd_oor) || w_wr_bad) begin
        err_q <= 1'b1;
      end
    end
  end

  assign req_mem_stall = stall_q;
  assign rsp_mem_push  = push_q;
  assign rsp_mem_tag   = tag_q;
  assign rsp_mem_q     = data_q;
  assign addr_err      = err_q;
endmodule

`default_nettype wire
